// File: rtl/x7seg_scan_if.sv
// -----------------------------------------------------------------------------
// x7seg_scan_if
//   Bundle between a datapath/register block and the multiplexed 7-segment
//   scanner.
//   master : the data source. Drives the display contents and brightness.
//   slave  : the scanner. Drives the board anode/segment pins and the frame
//            pulse.
// Signals
//   x      [4*NDIG]  hex nibbles, x[4i+3:4i] = digit i (NDIG-1 is most sig.)
//   dp_in  [NDIG]    decimal point request per digit
//   blank  [NDIG]    1 = force digit i dark
//   lz_en            1 = suppress leading zeros
//   bright [4]       PWM duty 0..15 (not frame-shadowed)
//   a_to_g [7]       segments, [6]=a .. [0]=g
//   dp               decimal point segment
//   an     [NDIG]    digit enables
//   frame            1-cycle pulse when a new shadow set is loaded
// -----------------------------------------------------------------------------
interface x7seg_scan_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] x;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   blank;
  logic              lz_en;
  logic [3:0]        bright;
  logic [6:0]        a_to_g;
  logic              dp;
  logic [NDIG-1:0]   an;
  logic              frame;

  modport master (
    output x, dp_in, blank, lz_en, bright,
    input  a_to_g, dp, an, frame
  );

  modport slave (
    input  x, dp_in, blank, lz_en, bright,
    output a_to_g, dp, an, frame
  );
endinterface

// File: rtl/x7seg_scan.sv
// -----------------------------------------------------------------------------
// x7seg_scan
//   Multiplexed hex 7-segment driver for NDIG digits. One digit is scanned per
//   refresh slot of 2**DIV_BITS clocks; its nibble is decoded to a_to_g.
//   Supports per-digit decimal points, per-digit blanking, leading-zero
//   suppression and 16-step PWM brightness. Display contents are shadowed once
//   per frame so a frame never mixes old and new data.
// Parameters
//   NDIG      number of digits (2..16)
//   DIV_BITS  refresh prescaler width (>=4)
//   AN_LOW    1: anodes active-low, 0: active-high
//   SEG_LOW   1: segments/dp active-low, 0: active-high
// Ports
//   clk   system clock
//   clr   asynchronous reset, active-low
//   bus   x7seg_scan_if slave modport (inputs x/dp_in/blank/lz_en/bright,
//         outputs a_to_g/dp/an/frame)
// -----------------------------------------------------------------------------
module x7seg_scan #(
  parameter int NDIG     = 4,
  parameter int DIV_BITS = 18,
  parameter bit AN_LOW   = 1'b1,
  parameter bit SEG_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  x7seg_scan_if.slave  bus
);

  localparam int              IDX_W    = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  // Inactive levels of the pins, used on reset and whenever nothing is lit.
  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{AN_LOW}};
  localparam logic [6:0]      SEG_OFF = {7{SEG_LOW}};
  localparam logic            DP_OFF  = SEG_LOW;

  // Active-high abcdefg pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h1F;
      4'hC:    seg = 7'h4E;
      4'hD:    seg = 7'h3D;
      4'hE:    seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

  // Scan state
  logic [DIV_BITS-1:0] r_pre;
  logic [IDX_W-1:0]    r_idx;
  logic                r_load_pend;

  // Frame shadow of the display contents
  logic [4*NDIG-1:0]   r_x;
  logic [NDIG-1:0]     r_dp;
  logic [NDIG-1:0]     r_blank;
  logic                r_lz;

  // Registered pin drivers
  logic [NDIG-1:0]     r_an;
  logic [6:0]          r_a_to_g;
  logic                r_dp_out;
  logic                r_frame;

  logic                w_tick;
  logic                w_load;
  logic [3:0]          w_phase;
  logic                w_on;
  logic [NDIG-1:0]     w_dark;
  logic [NDIG-1:0]     w_onehot;
  logic [3:0]          w_nib;
  logic                w_sel_dark;
  logic                w_sel_dp;
  logic                w_lit;

  assign w_tick  = &r_pre;
  // load_pend forces a reload on the first clock after reset so the display
  // never runs a whole frame on the reset-cleared shadow.
  assign w_load  = (w_tick && (r_idx == LAST_IDX)) || r_load_pend;

  // PWM: the top four prescaler bits sweep 0..15 once per slot; bright==15
  // keeps the digit lit across the whole slot including phase 15.
  assign w_phase = r_pre[DIV_BITS-1 -: 4];
  assign w_on    = (bus.bright == 4'hF) || (w_phase < bus.bright);

  // Digit i is dark when blanked, or when leading-zero suppression is on and
  // it and every more significant nibble are zero. Digit 0 always shows.
  always_comb begin
    logic run_zero;
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a missed path infers a latch.
    w_dark   = '0;
    run_zero = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run_zero  = run_zero & (r_x[4*i +: 4] == 4'h0);
      w_dark[i] = r_blank[i] | (r_lz & run_zero & (i != 0));
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    w_onehot   = '0;
    w_nib      = 4'h0;
    w_sel_dark = 1'b1;
    w_sel_dp   = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_nib       = r_x[4*i +: 4];
        w_sel_dark  = w_dark[i];
        w_sel_dp    = r_dp[i];
      end
    end
  end

  assign w_lit = w_on & ~w_sel_dark;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pre       <= '0;
      r_idx       <= '0;
      r_load_pend <= 1'b1;
      // NOTE: the shadow is reset, not left undefined, so the one output
      // cycle computed before the first reload shows a known value.
      r_x         <= '0;
      r_dp        <= '0;
      r_blank     <= '0;
      r_lz        <= 1'b0;
      r_an        <= AN_OFF;
      r_a_to_g    <= SEG_OFF;
      r_dp_out    <= DP_OFF;
      r_frame     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register here samples the pre-edge values of the others.
      r_pre <= r_pre + DIV_BITS'(1);

      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end

      if (w_load) begin
        r_x         <= bus.x;
        r_dp        <= bus.dp_in;
        r_blank     <= bus.blank;
        r_lz        <= bus.lz_en;
        r_load_pend <= 1'b0;
      end
      r_frame <= w_load;

      // Pins reflect the idx/pre state of the previous cycle.
      r_an     <= w_lit ? (w_onehot ^ AN_OFF) : AN_OFF;
      r_a_to_g <= (w_lit ? seg_decode(w_nib) : 7'h00) ^ SEG_OFF;
      r_dp_out <= (w_lit & w_sel_dp) ^ DP_OFF;
    end
  end

  assign bus.an     = r_an;
  assign bus.a_to_g = r_a_to_g;
  assign bus.dp     = r_dp_out;
  assign bus.frame  = r_frame;

endmodule
